// File: rtl/mmio_uart_tx_pkg.sv
// Types, constants and the STATUS word packer for the MMIO UART transmitter.
package mmio_uart_tx_pkg;

`include "uart_defs.vh"

  typedef enum logic [1:0] {
    ST_IDLE  = `UART_ST_IDLE,
    ST_START = `UART_ST_START,
    ST_DATA  = `UART_ST_DATA,
    ST_STOP  = `UART_ST_STOP
  } tx_state_e;

  localparam logic OFF_TXDATA = `UART_OFF_TXDATA;
  localparam logic OFF_STATUS = `UART_OFF_STATUS;

  localparam int STAT_FULL    = `UART_STAT_FULL;
  localparam int STAT_EMPTY   = `UART_STAT_EMPTY;
  localparam int STAT_BUSY    = `UART_STAT_BUSY;
  localparam int STAT_OVF     = `UART_STAT_OVF;
  localparam int STAT_CNT_LSB = `UART_STAT_CNT_LSB;
  localparam int STAT_CNT_MSB = `UART_STAT_CNT_MSB;

  function automatic logic [31:0] status_word(
    input logic       full,
    input logic       empty,
    input logic       busy,
    input logic       ovf,
    input logic [4:0] cnt
  );
    logic [31:0] w;
    w = '0;
    w[STAT_FULL]                  = full;
    w[STAT_EMPTY]                 = empty;
    w[STAT_BUSY]                  = busy;
    w[STAT_OVF]                   = ovf;
    w[STAT_CNT_MSB:STAT_CNT_LSB]  = cnt;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is taken only when a pop happens in
// the same cycle, so occupancy never exceeds DEPTH.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only read behind a non-zero count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_defs.vh
// Shared encodings for the MMIO UART transmitter: serializer states,
// register offsets (addr[2]) and STATUS bit positions.
`ifndef UART_DEFS_VH
`define UART_DEFS_VH

`define UART_ST_IDLE      2'd0
`define UART_ST_START     2'd1
`define UART_ST_DATA      2'd2
`define UART_ST_STOP      2'd3

`define UART_OFF_TXDATA   1'b0
`define UART_OFF_STATUS   1'b1

`define UART_STAT_FULL    0
`define UART_STAT_EMPTY   1
`define UART_STAT_BUSY    2
`define UART_STAT_OVF     3
`define UART_STAT_CNT_LSB 4
`define UART_STAT_CNT_MSB 8

`endif

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS register window, transmit
// FIFO and an 8N1 serializer with a registered line output.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int          CLK_DIV    = 868,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

  // Bus decode
  logic sel, off;
  logic push, ovf_clr;

  assign sel     = cs && (addr[31:3] == BASE_ADDR[31:3]);
  assign off     = addr[2];
  assign push    = sel && wr && (off == OFF_TXDATA);
  assign ovf_clr = sel && wr && (off == OFF_STATUS) && wdata[STAT_OVF];

  logic unused_bus_bits;
  assign unused_bus_bits = ^{addr[1:0], wdata[31:8]};

  // FIFO
  logic          pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_rdata;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Serializer state
  tx_state_e   state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [15:0] baud_q, baud_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;
  logic        busy;

  assign busy = (state_q != ST_IDLE);
  assign tx   = tx_q;
  assign irq  = fifo_empty && !busy;

  // tx_d is the line level for the next cycle, so each state transition
  // also sets the level of the state being entered.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    baud_d    = baud_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shreg_d   = fifo_rdata;
          bit_idx_d = '0;
          baud_d    = BAUD_RELOAD;
          tx_d      = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (baud_q == 16'd0) begin
          baud_d  = BAUD_RELOAD;
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_q == 16'd0) begin
          baud_d    = BAUD_RELOAD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_q == 16'd0) begin
          tx_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // A push while full only succeeds alongside a pop; otherwise it is dropped.
  always_comb begin
    ovf_d = ovf_q;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
    else if (ovf_clr)              ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      baud_q    <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      baud_q    <= baud_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
    end
  end

  // Read data is combinational for single-cycle CPU loads.
  always_comb begin
    rdata = '0;
    if (sel && rd) begin
      if (off == OFF_STATUS) begin
        rdata = status_word(fifo_full, fifo_empty, busy, ovf_q, 5'(fifo_count));
      end
    end
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 868, clock cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries; power of two, 2..16.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_1000, byte address of the register window; 8-byte aligned.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: the same clock as the CPU and data memory; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port cs, input, 1 bit: data-bus chip select (CPU DM_CS).
REQ-008 SHALL have port rd, input, 1 bit: data-bus read strobe (DM_R).
REQ-009 SHALL have port wr, input, 1 bit: data-bus write strobe (DM_W).
REQ-010 SHALL have port addr, input, 32 bits: data-bus byte address (DM_addr).
REQ-011 SHALL have port wdata, input, 32 bits: data-bus write data (DM_wdata).
REQ-012 SHALL have port rdata, output, 32 bits: register read data, muxed with DataMem rdata by the top level.
REQ-013 SHALL have port tx, output, 1 bit: UART serial line, idle high.
REQ-014 SHALL have port irq, output, 1 bit: high while the FIFO is empty and the serializer is idle.

Function
REQ-015 SHALL decode a register window as sel = cs && addr[31:3] == BASE_ADDR[31:3]; offset is addr[2].
REQ-016 SHALL, at offset 0 (TXDATA), push wdata[7:0] into the FIFO on the clk edge when sel && wr; reads return 0.
REQ-017 SHALL, at offset 4 (STATUS), return bit0 full, bit1 empty, bit2 serializer busy, bit3 sticky overflow, bits[8:4] count, all other bits 0.
REQ-018 SHALL clear overflow on a STATUS write with wdata[3]=1; other STATUS write bits are ignored.
REQ-019 SHALL drive rdata combinationally in the same cycle as sel && rd (single-cycle CPU timing), and drive 0 when not selected.
REQ-020 SHALL, on a push while full with no same-cycle pop, drop the byte and set overflow; FIFO contents are unchanged.
REQ-021 SHALL accept a push while full when a pop occurs in the same cycle; count is unchanged and overflow stays clear.
REQ-022 SHALL implement the serializer FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-023 SHALL, in IDLE, hold tx=1; when the FIFO is non-empty, pop the head into an 8-bit shift register and enter START on the next edge.
REQ-024 SHALL hold each of START (tx=0), the 8 DATA bits (LSB first) and STOP (tx=1) for exactly CLK_DIV cycles, timed by a 16-bit down-counter reloaded to CLK_DIV-1.
REQ-025 SHALL return from STOP to IDLE; the inter-frame gap is therefore exactly 1 cycle when the FIFO is non-empty.
REQ-026 SHALL use a 3-bit bit index that wraps 7 -> STOP; no ninth data bit.
REQ-027 SHALL register tx as a flop output, with no combinational path from the bus to tx.

Reset
REQ-028 SHALL, on assertion of rst, set immediately: state IDLE, tx=1, FIFO empty, pointers 0, count 0, overflow 0, baud counter 0, irq=1.
REQ-029 SHALL abort a frame in flight when rst asserts mid-frame; the line returns high and no partial frame resumes after reset.
REQ-030 SHALL keep rdata combinational: 0 in reset unless selected, and the STATUS reset value 32'h0000_0002.

Structure
REQ-031 SHALL place FSM state encodings, register offsets and STATUS bit positions in a shared definitions file, uart_defs.vh, included by the RTL and the bench.
REQ-032 SHALL instantiate one sub-module, sync_fifo, parameterized by width 8 and FIFO_DEPTH, with push/pop/full/empty/count outputs.

Verification (CLK_DIV=4, BASE_ADDR=32'h1000)
REQ-033 SHALL verify: write 32'hA5 to 0x1000 -> tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, high 4 cycles; frame 40 cycles after pop.
REQ-034 SHALL verify: 9 back-to-back writes with DEPTH=8 -> STATUS count reaches 8, 9th write accepted only if it coincides with the first pop, else overflow=1, STATUS bit3=1.
REQ-035 SHALL verify: write 32'h8 to 0x1004 with overflow set -> next-cycle STATUS bit3=0, count unchanged.
REQ-036 SHALL verify: assert rst 13 cycles into a frame -> tx=1 at once, STATUS reads 32'h0000_0002, no further tx transitions.
REQ-037 SHALL verify: read 0x1008 and read with cs=0 -> rdata=0, no FIFO change.
REQ-038 SHALL verify: two queued bytes -> exactly 1 idle cycle between the first STOP and the second START.
